// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I decode constants for the decode stage and the ALU control:
//   - base opcodes of the supported instruction classes
//   - aluOp encodings passed from decode to ALU control
//   - canonical NOP word (addi x0,x0,0)
//   - decodeCtrl(): opcode -> control bundle
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU control uses aluOp to decide how much of funct it must look at.
    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,   // address generation for load/store
        ALUOP_BRANCH = 2'b01,   // compare for branches
        ALUOP_RTYPE  = 2'b10,   // full funct decode
        ALUOP_IALU   = 2'b11    // funct3 decode, funct7 only for shifts
    } aluOp_t;

    localparam logic [31:0] NOP_VALUE = 32'h0000_0013;

    typedef struct packed {
        logic   legal;
        logic   regWrite;
        logic   memRead;
        logic   memWrite;
        logic   branch;
        logic   aluSrc;
        logic   usesRs2;    // rs2 is a real source operand (hazard relevant)
        logic   writesRd;   // rd field is a real destination
        aluOp_t aluOp;
    } ctrl_t;

    // Opcode -> controls. Unknown opcodes return an all-zero bundle with
    // legal=0 so the caller can flag them while issuing no side effects.
    function automatic ctrl_t decodeCtrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        c.aluOp = ALUOP_ADD;
        case (opcode)
            OPC_RTYPE: begin
                c.legal    = 1'b1;
                c.regWrite = 1'b1;
                c.usesRs2  = 1'b1;
                c.writesRd = 1'b1;
                c.aluOp    = ALUOP_RTYPE;
            end
            OPC_IALU: begin
                c.legal    = 1'b1;
                c.regWrite = 1'b1;
                c.aluSrc   = 1'b1;
                c.writesRd = 1'b1;
                c.aluOp    = ALUOP_IALU;
            end
            OPC_LOAD: begin
                c.legal    = 1'b1;
                c.regWrite = 1'b1;
                c.memRead  = 1'b1;
                c.aluSrc   = 1'b1;
                c.writesRd = 1'b1;
                c.aluOp    = ALUOP_ADD;
            end
            OPC_STORE: begin
                c.legal    = 1'b1;
                c.memWrite = 1'b1;
                c.aluSrc   = 1'b1;
                c.usesRs2  = 1'b1;
                c.aluOp    = ALUOP_ADD;
            end
            OPC_BRANCH: begin
                c.legal    = 1'b1;
                c.branch   = 1'b1;
                c.usesRs2  = 1'b1;
                c.aluOp    = ALUOP_BRANCH;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator for the decode stage.
//   instr [31:0]  in   instruction word from the IF/ID register
//   imm   [31:0]  out  sign-extended immediate (I for ALU-imm/load, S for
//                      store, B for branch, 0 for R-type and unknown opcodes)
// -----------------------------------------------------------------------------
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (instr[6:0])
            OPC_IALU, OPC_LOAD:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// IF/ID pipeline register, instruction decode, load-use hazard detection and
// ID/EX pipeline register of a 5-stage RV32I pipeline.
//   clock                in   rising-edge clock
//   reset                in   asynchronous active-low reset
//   in_valid/pc/instr    in   fetched instruction and its PC
//   flush                in   taken branch: kill decode and the incoming word
//   ex_memRead, ex_rd    in   load currently in execute (hazard source)
//   stall                out  combinational; fetch holds PC/instr while high
//   readReg1, readReg2   out  combinational rs1/rs2 to the register file
//   out_*                out  registered ID/EX fields and controls
// -----------------------------------------------------------------------------
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_VALUE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        flush,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic [4:0]  readReg1,
    output logic [4:0]  readReg2,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [4:0]  out_writeReg,
    output logic [31:0] out_imm,
    output logic [3:0]  out_funct,
    output logic [1:0]  out_aluOp,
    output logic        out_regWrite,
    output logic        out_memRead,
    output logic        out_memWrite,
    output logic        out_branch,
    output logic        out_aluSrc,
    output logic        out_illegal
);

    // IF/ID register
    logic        ifidValidReg;
    logic [31:0] ifidPcReg;
    logic [31:0] ifidInstrReg;

    ctrl_t       ctrl;
    logic [31:0] immValue;
    logic [4:0]  rdField;
    logic        hazard;
    logic        bubble;

    // Register-file addresses come straight from IF/ID so the read data and
    // the decoded controls land in ID/EX on the same edge.
    assign readReg1 = ifidInstrReg[19:15];
    assign readReg2 = ifidInstrReg[24:20];
    assign rdField  = ifidInstrReg[11:7];

    assign ctrl = decodeCtrl(ifidInstrReg[6:0]);

    imm_gen u_immGen (
        .instr (ifidInstrReg),
        .imm   (immValue)
    );

    // Load-use hazard: the load in execute has not produced its data yet.
    // rs1 is compared unconditionally (cheap, and a spurious stall on an
    // instruction without rs1 only costs one cycle).
    assign hazard = ifidValidReg && ex_memRead && (ex_rd != 5'd0) &&
                    ((ex_rd == readReg1) || (ctrl.usesRs2 && (ex_rd == readReg2)));

    // A flush discards the stalled instruction anyway, so it wins.
    assign stall  = hazard && !flush;
    assign bubble = flush || stall || !ifidValidReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifidValidReg <= 1'b0;
            ifidPcReg    <= 32'd0;
            ifidInstrReg <= NOP_INSTR;
        end else if (flush) begin
            ifidValidReg <= 1'b0;
            ifidInstrReg <= NOP_INSTR;
        end else if (!stall) begin
            ifidValidReg <= in_valid;
            ifidPcReg    <= in_pc;
            ifidInstrReg <= in_instr;
        end
    end

    // ID/EX register. Bubbles also zero the data fields so the EX stage sees
    // a clean all-zero word rather than stale decode results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_pc       <= 32'd0;
            out_writeReg <= 5'd0;
            out_imm      <= 32'd0;
            out_funct    <= 4'd0;
            out_aluOp    <= 2'd0;
            out_regWrite <= 1'b0;
            out_memRead  <= 1'b0;
            out_memWrite <= 1'b0;
            out_branch   <= 1'b0;
            out_aluSrc   <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (bubble) begin
            out_valid    <= 1'b0;
            out_pc       <= 32'd0;
            out_writeReg <= 5'd0;
            out_imm      <= 32'd0;
            out_funct    <= 4'd0;
            out_aluOp    <= 2'd0;
            out_regWrite <= 1'b0;
            out_memRead  <= 1'b0;
            out_memWrite <= 1'b0;
            out_branch   <= 1'b0;
            out_aluSrc   <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            // An illegal opcode still travels as a valid slot so the
            // exception logic downstream can attach it to out_pc; decodeCtrl
            // has already zeroed all of its side-effect controls.
            out_valid    <= 1'b1;
            out_pc       <= ifidPcReg;
            out_writeReg <= ctrl.writesRd ? rdField : 5'd0;
            out_imm      <= immValue;
            out_funct    <= {ifidInstrReg[30], ifidInstrReg[14:12]};
            out_aluOp    <= ctrl.aluOp;
            // Writes to x0 are architecturally discarded; drop them here.
            out_regWrite <= ctrl.regWrite && (rdField != 5'd0);
            out_memRead  <= ctrl.memRead;
            out_memWrite <= ctrl.memWrite;
            out_branch   <= ctrl.branch;
            out_aluSrc   <= ctrl.aluSrc;
            out_illegal  <= !ctrl.legal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: directed scenarios followed by a
// randomized run compared against a behavioural pipeline model.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADD3    = 32'h0020_81B3;   // add x3,x1,x2
    localparam logic [31:0] LW5     = 32'hFFC1_2283;   // lw  x5,-4(x2)
    localparam logic [31:0] ADD6    = 32'h0012_8333;   // add x6,x5,x1
    localparam logic [31:0] ILL     = 32'h0000_007F;   // opcode 1111111
    localparam logic [31:0] ADDI_X0 = 32'h0010_0013;   // addi x0,x0,1

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        ex_memRead;
    logic [4:0]  ex_rd;
    logic        stall;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [4:0]  out_writeReg;
    logic [31:0] out_imm;
    logic [3:0]  out_funct;
    logic [1:0]  out_aluOp;
    logic        out_regWrite;
    logic        out_memRead;
    logic        out_memWrite;
    logic        out_branch;
    logic        out_aluSrc;
    logic        out_illegal;

    int nAsserts = 0;
    int nFails   = 0;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .ex_memRead   (ex_memRead),
        .ex_rd        (ex_rd),
        .stall        (stall),
        .readReg1     (readReg1),
        .readReg2     (readReg2),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_writeReg (out_writeReg),
        .out_imm      (out_imm),
        .out_funct    (out_funct),
        .out_aluOp    (out_aluOp),
        .out_regWrite (out_regWrite),
        .out_memRead  (out_memRead),
        .out_memWrite (out_memWrite),
        .out_branch   (out_branch),
        .out_aluSrc   (out_aluSrc),
        .out_illegal  (out_illegal)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_m;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        branch;
        logic        aluSrc;
        logic        illegal;
        logic [1:0]  aluOp;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  funct;
    } idex_m;

    ifid_m mIfid;
    idex_m mIdex;

    // Immediates computed as signed integers from bit weights.
    function automatic idex_m refDecode(input ifid_m f, input logic kill);
        idex_m       e;
        logic [31:0] w;
        int          v;
        e = '0;
        w = f.instr;
        if (kill) return e;
        e.valid = 1'b1;
        e.pc    = f.pc;
        e.funct = {w[30], w[14:12]};
        case (w[6:0])
            7'h33: begin
                e.regWrite = 1'b1; e.aluOp = 2'd2; e.wr = w[11:7]; e.imm = 32'd0;
            end
            7'h13, 7'h03: begin
                v = int'(w[31:20]);
                if (w[31]) v = v - 4096;
                e.imm      = v;
                e.regWrite = 1'b1;
                e.aluSrc   = 1'b1;
                e.wr       = w[11:7];
                e.memRead  = (w[6:0] == 7'h03);
                e.aluOp    = (w[6:0] == 7'h13) ? 2'd3 : 2'd0;
            end
            7'h23: begin
                v = int'(w[31:25]) * 32 + int'(w[11:7]);
                if (w[31]) v = v - 4096;
                e.imm = v; e.memWrite = 1'b1; e.aluSrc = 1'b1; e.aluOp = 2'd0;
            end
            7'h63: begin
                v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                if (w[31]) v = v - 4096;
                e.imm = v; e.branch = 1'b1; e.aluOp = 2'd1;
            end
            default: e.illegal = 1'b1;
        endcase
        if (e.wr == 5'd0) e.regWrite = 1'b0;
        return e;
    endfunction

    function automatic logic refStall();
        logic [6:0] op;
        logic       uses2;
        op    = mIfid.instr[6:0];
        uses2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
        return !flush && mIfid.valid && ex_memRead && (ex_rd != 5'd0) &&
               ((ex_rd == mIfid.instr[19:15]) || (uses2 && ex_rd == mIfid.instr[24:20]));
    endfunction

    task automatic modelReset();
        mIfid = '{valid: 1'b0, pc: 32'd0, instr: NOP};
        mIdex = '0;
    endtask

    // Drive inputs on the falling edge, leave 1 time unit to settle.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic fl, input logic mr, input logic [4:0] rd);
        @(negedge clock);
        in_valid = v; in_pc = pc; in_instr = instr;
        flush = fl; ex_memRead = mr; ex_rd = rd;
        #1;
    endtask

    // One rising edge; the model advances with the same inputs.
    task automatic tick();
        logic  st;
        idex_m n;
        st = refStall();
        n  = refDecode(mIfid, flush || st || !mIfid.valid);
        @(posedge clock);
        mIdex = n;
        if (flush) begin
            mIfid.valid = 1'b0;
            mIfid.instr = NOP;
        end else if (!st) begin
            mIfid = '{valid: in_valid, pc: in_pc, instr: in_instr};
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] all;
        reset = 1'b0;
        in_valid = 1'b1; in_pc = 32'h10; in_instr = ADD3;
        flush = 1'b0; ex_memRead = 1'b0; ex_rd = 5'd0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        all = {out_valid, out_regWrite, out_memRead, out_memWrite, out_branch,
               out_aluSrc, out_illegal, out_aluOp, out_funct, out_writeReg,
               stall, readReg1, readReg2};
        nAsserts++;
        if (all !== 32'd0 || out_pc !== 32'd0 || out_imm !== 32'd0) begin
            nFails++;
            $display("FAIL reset_outputs: got ctl=%h pc=%h imm=%h, want all 0", all, out_pc, out_imm);
        end
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_add();
        drive(1'b1, 32'h100, ADD3, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        nAsserts++;
        if (readReg1 !== 5'd1 || readReg2 !== 5'd2 || stall !== 1'b0) begin
            nFails++;
            $display("FAIL add_readregs: got rs1=%0d rs2=%0d stall=%b, want 1 2 0", readReg1, readReg2, stall);
        end
        tick();
        nAsserts++;
        if (out_valid !== 1'b1 || out_regWrite !== 1'b1 || out_aluOp !== 2'b10 ||
            out_writeReg !== 5'd3 || out_pc !== 32'h100 || out_memRead !== 1'b0 || out_imm !== 32'd0) begin
            nFails++;
            $display("FAIL add_idex: got v=%b rw=%b op=%b wr=%0d pc=%h imm=%h, want 1 1 10 3 100 0",
                     out_valid, out_regWrite, out_aluOp, out_writeReg, out_pc, out_imm);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 32'h104, LW5, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        nAsserts++;
        if (out_imm !== 32'hFFFF_FFFC || out_memRead !== 1'b1 || out_aluSrc !== 1'b1 ||
            out_writeReg !== 5'd5 || out_regWrite !== 1'b1 || out_aluOp !== 2'b00 || out_memWrite !== 1'b0) begin
            nFails++;
            $display("FAIL load_idex: got imm=%h mr=%b src=%b wr=%0d rw=%b op=%b, want fffffffc 1 1 5 1 00",
                     out_imm, out_memRead, out_aluSrc, out_writeReg, out_regWrite, out_aluOp);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h200, ADD6, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 32'h204, ADD3, 1'b0, 1'b1, 5'd5);
        nAsserts++;
        if (stall !== 1'b1 || readReg1 !== 5'd5) begin
            nFails++;
            $display("FAIL loaduse_stall: got stall=%b rs1=%0d, want 1 5", stall, readReg1);
        end
        tick();
        nAsserts++;
        if (out_valid !== 1'b0 || out_regWrite !== 1'b0 || readReg1 !== 5'd5 || readReg2 !== 5'd1) begin
            nFails++;
            $display("FAIL loaduse_bubble: got v=%b rw=%b rs1=%0d rs2=%0d, want 0 0 5 1",
                     out_valid, out_regWrite, readReg1, readReg2);
        end
        drive(1'b1, 32'h204, ADD3, 1'b0, 1'b0, 5'd5);
        nAsserts++;
        if (stall !== 1'b0) begin
            nFails++;
            $display("FAIL loaduse_release: got stall=%b, want 0", stall);
        end
        tick();
        nAsserts++;
        if (out_valid !== 1'b1 || out_regWrite !== 1'b1 || out_writeReg !== 5'd6 || out_pc !== 32'h200) begin
            nFails++;
            $display("FAIL loaduse_issue: got v=%b rw=%b wr=%0d pc=%h, want 1 1 6 200",
                     out_valid, out_regWrite, out_writeReg, out_pc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h300, ADD6, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 32'h304, ADD3, 1'b1, 1'b1, 5'd5);
        nAsserts++;
        if (stall !== 1'b0) begin
            nFails++;
            $display("FAIL flush_masks_stall: got stall=%b, want 0", stall);
        end
        tick();
        nAsserts++;
        if (out_valid !== 1'b0 || dut.ifidInstrReg !== NOP || dut.ifidValidReg !== 1'b0 ||
            readReg1 !== 5'd0 || readReg2 !== 5'd0) begin
            nFails++;
            $display("FAIL flush_result: got v=%b ifid=%h ifv=%b rs1=%0d rs2=%0d, want 0 00000013 0 0 0",
                     out_valid, dut.ifidInstrReg, dut.ifidValidReg, readReg1, readReg2);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h400, ILL, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 32'h404, ADDI_X0, 1'b0, 1'b0, 5'd0);
        tick();
        nAsserts++;
        if (out_illegal !== 1'b1 || out_regWrite !== 1'b0 || out_memWrite !== 1'b0 ||
            out_memRead !== 1'b0 || out_branch !== 1'b0) begin
            nFails++;
            $display("FAIL illegal_flag: got ill=%b rw=%b mw=%b mr=%b br=%b, want 1 0 0 0 0",
                     out_illegal, out_regWrite, out_memWrite, out_memRead, out_branch);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        nAsserts++;
        if (out_illegal !== 1'b0 || out_valid !== 1'b1 || out_regWrite !== 1'b0 ||
            out_aluSrc !== 1'b1 || out_imm !== 32'd1) begin
            nFails++;
            $display("FAIL addi_x0: got ill=%b v=%b rw=%b src=%b imm=%h, want 0 1 0 1 1",
                     out_illegal, out_valid, out_regWrite, out_aluSrc, out_imm);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] all;
        drive(1'b1, 32'h500, ADD6, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 32'h504, ADD3, 1'b0, 1'b1, 5'd5);
        tick();   // stall cycle: ADD6 held, bubble issued
        drive(1'b1, 32'h504, ADD3, 1'b0, 1'b1, 5'd5);
        #1;
        reset = 1'b0;
        modelReset();
        #1;
        all = {out_valid, out_regWrite, out_memRead, out_memWrite, out_branch,
               out_aluSrc, out_illegal, out_aluOp, out_funct, out_writeReg,
               stall, readReg1, readReg2};
        nAsserts++;
        if (all !== 32'd0 || out_pc !== 32'd0 || out_imm !== 32'd0) begin
            nFails++;
            $display("FAIL async_reset: got ctl=%h pc=%h imm=%h, want all 0", all, out_pc, out_imm);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b1; in_pc = 32'h600; in_instr = ADD3;
        flush = 1'b0; ex_memRead = 1'b0; ex_rd = 5'd0;
        #1;
        tick();
        nAsserts++;
        if (readReg1 !== 5'd1 || readReg2 !== 5'd2 || dut.ifidValidReg !== 1'b1) begin
            nFails++;
            $display("FAIL reset_release_load: got rs1=%0d rs2=%0d ifv=%b, want 1 2 1",
                     readReg1, readReg2, dut.ifidValidReg);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        nAsserts++;
        if (out_valid !== 1'b1 || out_writeReg !== 5'd3 || out_pc !== 32'h600) begin
            nFails++;
            $display("FAIL reset_release_issue: got v=%b wr=%0d pc=%h, want 1 3 600",
                     out_valid, out_writeReg, out_pc);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [6];
        logic [31:0] w;
        logic [31:0] pc;
        logic [4:0]  rdSel;
        logic        st;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h7F;
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom);
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            w[11:7]  = 5'($urandom_range(0, 3));
            rdSel    = 5'($urandom_range(0, 3));
            drive(($urandom_range(0, 9) < 8), pc, w, ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 1) == 1), rdSel);
            st = refStall();
            nAsserts++;
            if (stall !== st || readReg1 !== mIfid.instr[19:15] || readReg2 !== mIfid.instr[24:20]) begin
                nFails++;
                $display("FAIL rand_comb[%0d]: got stall=%b rs1=%0d rs2=%0d, want %b %0d %0d",
                         i, stall, readReg1, readReg2, st, mIfid.instr[19:15], mIfid.instr[24:20]);
            end
            tick();
            if (!st) pc = pc + 32'd4;
            nAsserts++;
            if ({out_valid, out_regWrite, out_memRead, out_memWrite, out_branch,
                 out_aluSrc, out_illegal} !==
                {mIdex.valid, mIdex.regWrite, mIdex.memRead, mIdex.memWrite, mIdex.branch,
                 mIdex.aluSrc, mIdex.illegal}) begin
                nFails++;
                $display("FAIL rand_ctrl[%0d]: got v/rw/mr/mw/br/src/ill=%b%b%b%b%b%b%b, want %b%b%b%b%b%b%b",
                         i, out_valid, out_regWrite, out_memRead, out_memWrite, out_branch,
                         out_aluSrc, out_illegal, mIdex.valid, mIdex.regWrite, mIdex.memRead,
                         mIdex.memWrite, mIdex.branch, mIdex.aluSrc, mIdex.illegal);
            end
            if (mIdex.valid && !mIdex.illegal) begin
                nAsserts++;
                if (out_pc !== mIdex.pc || out_writeReg !== mIdex.wr || out_imm !== mIdex.imm ||
                    out_funct !== mIdex.funct || out_aluOp !== mIdex.aluOp) begin
                    nFails++;
                    $display("FAIL rand_fields[%0d]: got pc=%h wr=%0d imm=%h f=%h op=%b, want %h %0d %h %h %b",
                             i, out_pc, out_writeReg, out_imm, out_funct, out_aluOp,
                             mIdex.pc, mIdex.wr, mIdex.imm, mIdex.funct, mIdex.aluOp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_load_use();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
